// File: rtl/mult_seq_param_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_seq_param_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int STATE_W = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // The hold counter needs at least one bit even when DONE_HOLD is 1.
  function automatic int hold_cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mult_seq_param_if.sv
// Bus-side handshake and operand/result signals of the multiplier.
interface mult_seq_param_if #(
  parameter int WIDTH = 16
);
  logic               init;
  logic               ack;
  logic               signed_mode;
  logic [WIDTH-1:0]   op_A;
  logic [WIDTH-1:0]   op_B;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;

  modport master (
    output init, ack, signed_mode, op_A, op_B,
    input  busy, done, result
  );

  modport slave (
    input  init, ack, signed_mode, op_A, op_B,
    output busy, done, result
  );
endinterface

// File: rtl/mult_seq_param_abs.sv
// Operand magnitude: two's-complement absolute value in signed mode, pass-through otherwise.
module mult_seq_param_abs #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] val,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] mag
);
  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  assign mag = (signed_mode && val[WIDTH-1]) ? (~val + WIDTH'(1)) : val;
endmodule

// File: rtl/mult_seq_param.sv
// WIDTH-generic shift-add multiplier with signed mode, early exit on an exhausted
// multiplier and a done flag released by ack or after DONE_HOLD cycles.
module mult_seq_param
  import mult_seq_param_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DONE_HOLD = 32
) (
  input  logic            clk,
  input  logic            reset,
  mult_seq_param_if.slave bus
);

  localparam int            CW        = hold_cnt_width(DONE_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(DONE_HOLD - 1);

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 neg_q, neg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic [WIDTH-1:0] op_in  [2];
  logic [WIDTH-1:0] op_mag [2];

  assign op_in[0] = bus.op_A;
  assign op_in[1] = bus.op_B;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_abs
      mult_seq_param_abs #(.WIDTH(WIDTH)) u_abs (
        .val         (op_in[gi]),
        .signed_mode (bus.signed_mode),
        .mag         (op_mag[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.init) begin
          a_d      = {{WIDTH{1'b0}}, op_mag[0]};
          b_d      = op_mag[1];
          acc_d    = '0;
          result_d = '0;
          neg_d    = bus.signed_mode & (bus.op_A[WIDTH-1] ^ bus.op_B[WIDTH-1]);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // Stop as soon as no multiplier bits remain; short operands finish early.
        if (b_q == '0) begin
          state_d = S_FIX;
        end else begin
          acc_d = acc_q + (b_q[0] ? a_q : '0);
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end
      end
      S_FIX: begin
        result_d = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
        cnt_d    = '0;
        state_d  = S_DONE;
      end
      S_DONE: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.ack || (cnt_q == HOLD_LAST)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mult_seq_param.sv
// Randomised and directed checks of mult_seq_param against an arithmetic reference model.
module tb_mult_seq_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_seq_param_if #(.WIDTH(16)) m16 ();
  mult_seq_param_if #(.WIDTH(8))  m8 ();

  mult_seq_param #(.WIDTH(16), .DONE_HOLD(32)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (m16.slave)
  );

  mult_seq_param #(.WIDTH(8), .DONE_HOLD(1)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (m8.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Product of the operands interpreted per mode, reduced to 2*w bits.
  function automatic longint unsigned ref_prod(input int w, input longint unsigned a,
                                               input longint unsigned b, input bit s);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return longint'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Edges from accept to done: bit length of |b| plus three.
  function automatic int ref_lat(input int w, input longint unsigned b, input bit s);
    longint unsigned m;
    int n;
    m = (s && b[w-1]) ? ((64'd1 << w) - b) : b;
    n = 0;
    while (m != 0) begin
      n++;
      m = m >> 1;
    end
    return n + 3;
  endfunction

  task automatic wait_done16(output int lat);
    lat = 1;
    while (!m16.done && lat < 60) begin
      tick;
      lat++;
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input bit s, input string tag);
    longint unsigned exp;
    int lat, exp_lat;
    exp     = ref_prod(16, a, b, s);
    exp_lat = ref_lat(16, b, s);
    m16.op_A = a; m16.op_B = b; m16.signed_mode = s; m16.init = 1'b1;
    tick;
    m16.init = 1'b0;
    checks++;
    if (m16.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy after accept got %b want 1", tag, m16.busy);
    end
    wait_done16(lat);
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", tag, lat, exp_lat);
    end
    checks++;
    if (m16.result !== exp[31:0]) begin
      errors++;
      $display("FAIL %s result got %h want %h", tag, m16.result, exp[31:0]);
    end
    $display("tx w16 %s a=%h b=%h s=%0d result=%h lat=%0d", tag, a, b, s, m16.result, lat);
  endtask

  task automatic release16(input string tag);
    m16.ack = 1'b1;
    tick;
    m16.ack = 1'b0;
    checks++;
    if (m16.done !== 1'b0 || m16.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release got done=%b busy=%b want 0 0", tag, m16.done, m16.busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick;
    tick;
    checks++;
    if (m16.busy !== 1'b0 || m16.done !== 1'b0 || m16.result !== 32'h0) begin
      errors++;
      $display("FAIL reset16 got busy=%b done=%b result=%h want 0", m16.busy, m16.done, m16.result);
    end
    checks++;
    if (m8.busy !== 1'b0 || m8.done !== 1'b0 || m8.result !== 16'h0) begin
      errors++;
      $display("FAIL reset8 got busy=%b done=%b result=%h want 0", m8.busy, m8.done, m8.result);
    end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_hold;
    int cnt;
    op16(16'd3, 16'd5, 1'b0, "u3x5");
    cnt = 0;
    while (m16.done && cnt < 100) begin
      cnt++;
      tick;
    end
    checks++;
    if (cnt != 32) begin
      errors++;
      $display("FAIL hold_len got %0d want 32", cnt);
    end
    checks++;
    if (m16.busy !== 1'b0 || m16.result !== 32'd15) begin
      errors++;
      $display("FAIL after_hold got busy=%b result=%h want 0 0000000f", m16.busy, m16.result);
    end
  endtask

  task automatic test_unsigned;
    op16(16'hFFFF, 16'hFFFF, 1'b0, "umax");
    release16("umax");
    op16(16'h1234, 16'h0000, 1'b0, "uzero");
    release16("uzero");
  endtask

  task automatic test_signed;
    op16(16'hFFFD, 16'd7, 1'b1, "sm3x7");
    release16("sm3x7");
    op16(16'h8000, 16'h8000, 1'b1, "sminmin");
    release16("sminmin");
    op16(16'h8000, 16'h0001, 1'b1, "sminx1");
    release16("sminx1");
  endtask

  task automatic test_ack_and_init_hold;
    int cnt, lat;
    op16(16'd3, 16'd5, 1'b0, "ack");
    tick;
    tick;
    checks++;
    if (m16.done !== 1'b1) begin
      errors++;
      $display("FAIL ack_pre done got %b want 1", m16.done);
    end
    m16.ack = 1'b1;
    tick;
    m16.ack = 1'b0;
    checks++;
    if (m16.done !== 1'b0) begin
      errors++;
      $display("FAIL ack_release done got %b want 0", m16.done);
    end
    // init held high: the second operand set must not be taken until IDLE returns.
    m16.op_A = 16'd6; m16.op_B = 16'd7; m16.signed_mode = 1'b0; m16.init = 1'b1;
    tick;
    m16.op_A = 16'd9; m16.op_B = 16'd10;
    wait_done16(lat);
    checks++;
    if (lat != 6 || m16.result !== 32'd42) begin
      errors++;
      $display("FAIL init_hold_first got lat=%0d result=%h want 6 0000002a", lat, m16.result);
    end
    cnt = 0;
    while (m16.done && cnt < 100) begin
      cnt++;
      tick;
    end
    checks++;
    if (cnt != 32 || m16.busy !== 1'b0) begin
      errors++;
      $display("FAIL init_hold_done got len=%0d busy=%b want 32 0", cnt, m16.busy);
    end
    tick;
    checks++;
    if (m16.busy !== 1'b1) begin
      errors++;
      $display("FAIL init_hold_restart busy got %b want 1", m16.busy);
    end
    m16.init = 1'b0;
    wait_done16(lat);
    checks++;
    if (lat != 7 || m16.result !== 32'd90) begin
      errors++;
      $display("FAIL init_hold_second got lat=%0d result=%h want 7 0000005a", lat, m16.result);
    end
    $display("tx w16 init_hold second result=%h lat=%0d", m16.result, lat);
    release16("init_hold");
  endtask

  task automatic test_reset_mid;
    m16.op_A = 16'hFFFF; m16.op_B = 16'hFFFF; m16.signed_mode = 1'b0; m16.init = 1'b1;
    tick;
    m16.init = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    checks++;
    if (m16.busy !== 1'b0 || m16.done !== 1'b0 || m16.result !== 32'h0) begin
      errors++;
      $display("FAIL reset_run got busy=%b done=%b result=%h want 0", m16.busy, m16.done, m16.result);
    end
    op16(16'd3, 16'd5, 1'b0, "pre_rst");
    reset = 1'b0;
    tick;
    reset = 1'b1;
    checks++;
    if (m16.busy !== 1'b0 || m16.done !== 1'b0 || m16.result !== 32'h0) begin
      errors++;
      $display("FAIL reset_done got busy=%b done=%b result=%h want 0", m16.busy, m16.done, m16.result);
    end
    op16(16'd2, 16'd3, 1'b0, "post_rst");
    release16("post_rst");
  endtask

  task automatic test_random16;
    logic [15:0] a, b;
    bit s;
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom_range(0, 1));
      op16(a, b, s, "rnd16");
      release16("rnd16");
    end
  endtask

  task automatic test_random8;
    logic [7:0] a, b;
    bit s;
    longint unsigned exp;
    int lat, exp_lat;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (i == 0) begin a = 8'h80; b = 8'h80; end
      if (i == 1) begin a = 8'h7F; b = 8'h00; end
      s = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      exp     = ref_prod(8, a, b, s);
      exp_lat = ref_lat(8, b, s);
      m8.op_A = a; m8.op_B = b; m8.signed_mode = s; m8.init = 1'b1;
      tick;
      m8.init = 1'b0;
      lat = 1;
      while (!m8.done && lat < 40) begin
        tick;
        lat++;
      end
      checks++;
      if (lat != exp_lat || m8.result !== exp[15:0]) begin
        errors++;
        $display("FAIL rnd8 got lat=%0d result=%h want %0d %h", lat, m8.result, exp_lat, exp[15:0]);
      end
      $display("tx w8 a=%h b=%h s=%0d result=%h lat=%0d", a, b, s, m8.result, lat);
      tick;
      checks++;
      if (m8.done !== 1'b0 || m8.busy !== 1'b0) begin
        errors++;
        $display("FAIL rnd8_hold got done=%b busy=%b want 0 0", m8.done, m8.busy);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    m16.init = 1'b0; m16.ack = 1'b0; m16.signed_mode = 1'b0; m16.op_A = '0; m16.op_B = '0;
    m8.init  = 1'b0; m8.ack  = 1'b0; m8.signed_mode  = 1'b0; m8.op_A  = '0; m8.op_B  = '0;
    test_reset;
    test_hold;
    test_unsigned;
    test_signed;
    test_ack_and_init_hold;
    test_reset_mid;
    test_random16;
    test_random8;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
